// File: rtl/vga_renderer.sv
// 640x480 VGA tile renderer: 25 MHz pixel tick from a 50 MHz clock, sync/blank timing, and a registered colour stage.
// Optional feature: define CURSOR_OVERLAY_EN to draw a yellow 2-pixel outline around the cursor tile.
module vga_renderer #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic       clock_50,
    input  logic       reset_key,
    input  logic [3:0] sprite,
    input  logic [1:0] robot_cursor_flags,
    input  logic [4:0] robot_type,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic [7:0] vga_r,
    output logic [7:0] vga_g,
    output logic [7:0] vga_b,
    output logic       vga_hs,
    output logic       vga_vs,
    output logic       vga_blank_n,
    output logic       vga_clk
);

    localparam logic [9:0] H_VIS      = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS      = 10'(V_VISIBLE);
    localparam logic [9:0] H_LAST     = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [9:0] V_LAST     = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [9:0] HS_FIRST   = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_LAST    = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST   = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_LAST    = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    logic        toggle;
    logic [9:0]  h_count;
    logic [9:0]  v_count;
    logic        visible;
    logic [4:0]  local_x;
    logic [4:0]  local_y;
    logic        marker_hit;
    logic [23:0] palette_rgb;
    logic [23:0] next_rgb;

    // The toggle doubles as the pixel clock; counters step on the cycle where it is high.
    always_ff @(posedge clock_50 or negedge reset_key) begin
        if (!reset_key) begin
            toggle  <= 1'b0;
            h_count <= '0;
            v_count <= '0;
        end else begin
            toggle <= ~toggle;
            if (toggle) begin
                if (h_count == H_LAST) begin
                    h_count <= '0;
                    v_count <= (v_count == V_LAST) ? '0 : v_count + 10'd1;
                end else begin
                    h_count <= h_count + 10'd1;
                end
            end
        end
    end

    assign vga_clk = toggle;
    assign visible = (h_count < H_VIS) && (v_count < V_VIS);
    assign pixel_x = (h_count < H_VIS) ? h_count : '0;
    assign pixel_y = (v_count < V_VIS) ? v_count : '0;
    assign local_x = pixel_x[4:0];
    assign local_y = pixel_y[4:0];

    always_comb begin
        palette_rgb = 24'hFF00FF;
        case (sprite)
            4'b0000: palette_rgb = 24'h808080;
            4'b0001: palette_rgb = 24'hF0F0F0;
            4'b0011: palette_rgb = 24'h8B4513;
            4'b0110: palette_rgb = 24'h000000;
            default: palette_rgb = 24'hFF00FF;
        endcase
    end

    // Malformed (non-one-hot) orientation codes fall back to the north marker.
    always_comb begin
        marker_hit = 1'b0;
        case (robot_type)
            5'b00000: marker_hit = 1'b0;
            5'b00100: marker_hit = (local_y[4:3] == 2'b11) && (local_x >= 5'd12) && (local_x <= 5'd19);
            5'b01000: marker_hit = (local_x[4:3] == 2'b11) && (local_y >= 5'd12) && (local_y <= 5'd19);
            5'b10000: marker_hit = (local_x[4:3] == 2'b00) && (local_y >= 5'd12) && (local_y <= 5'd19);
            default:  marker_hit = (local_y[4:3] == 2'b00) && (local_x >= 5'd12) && (local_x <= 5'd19);
        endcase
    end

`ifdef CURSOR_OVERLAY_EN
    logic cursor_border;
    assign cursor_border = robot_cursor_flags[0] &&
                           ((local_x <= 5'd1) || (local_x >= 5'd30) ||
                            (local_y <= 5'd1) || (local_y >= 5'd30));
`else
    logic cursor_unused;
    assign cursor_unused = robot_cursor_flags[0];
`endif

    always_comb begin
        next_rgb = palette_rgb;
        if (!visible)
            next_rgb = 24'h000000;
        else if (robot_cursor_flags[1])
            next_rgb = marker_hit ? 24'hFFFFFF : 24'hFF0000;
`ifdef CURSOR_OVERLAY_EN
        else if (cursor_border)
            next_rgb = 24'hFFFF00;
`endif
    end

    // Colour, syncs and blank share this single stage so they stay aligned.
    always_ff @(posedge clock_50 or negedge reset_key) begin
        if (!reset_key) begin
            {vga_r, vga_g, vga_b} <= 24'h000000;
            vga_hs      <= 1'b1;
            vga_vs      <= 1'b1;
            vga_blank_n <= 1'b0;
        end else if (toggle) begin
            {vga_r, vga_g, vga_b} <= next_rgb;
            vga_hs      <= !((h_count >= HS_FIRST) && (h_count <= HS_LAST));
            vga_vs      <= !((v_count >= VS_FIRST) && (v_count <= VS_LAST));
            vga_blank_n <= visible;
        end
    end

endmodule

// File: tb/tb_vga_renderer.sv
// Directed bench for vga_renderer, built with shrunken timing (128x64 visible, 144x72 total) so whole frames fit the run.
module tb_vga_renderer;
    localparam int HV = 128, HF = 4, HS = 8, HB = 4;
    localparam int VV = 64, VF = 2, VS = 2, VB = 4;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int FRAME_CLKS = HT * VT * 2;
`ifdef CURSOR_OVERLAY_EN
    localparam logic [23:0] CUR_RGB = 24'hFFFF00;
`else
    localparam logic [23:0] CUR_RGB = 24'hF0F0F0;
`endif

    logic       clock_50;
    logic       reset_key;
    logic [3:0] sprite;
    logic [1:0] robot_cursor_flags;
    logic [4:0] robot_type;
    logic [9:0] pixel_x, pixel_y;
    logic [7:0] vga_r, vga_g, vga_b;
    logic       vga_hs, vga_vs, vga_blank_n, vga_clk;
    logic [23:0] rgb;

    int vectors = 0;
    int miscompares = 0;
    int mode = 0;

    vga_renderer #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
    ) dut (
        .clock_50(clock_50), .reset_key(reset_key), .sprite(sprite),
        .robot_cursor_flags(robot_cursor_flags), .robot_type(robot_type),
        .pixel_x(pixel_x), .pixel_y(pixel_y),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank_n(vga_blank_n), .vga_clk(vga_clk)
    );

    assign rgb = {vga_r, vga_g, vga_b};

    initial clock_50 = 1'b0;
    always #5 clock_50 = ~clock_50;

    // Reference raster position, used only to know when a chosen pixel is being presented.
    logic m_tog;
    int   m_h, m_v;
    always_ff @(posedge clock_50 or negedge reset_key) begin
        if (!reset_key) begin
            m_tog <= 1'b0;
            m_h   <= 0;
            m_v   <= 0;
        end else begin
            m_tog <= !m_tog;
            if (m_tog) begin
                if (m_h == HT - 1) begin
                    m_h <= 0;
                    m_v <= (m_v == VT - 1) ? 0 : m_v + 1;
                end else begin
                    m_h <= m_h + 1;
                end
            end
        end
    end

    // World: mode 0 is all trash; mode 1 is a 4x2 tile map exercising each colour rule.
    always_comb begin
        sprite             = 4'b0011;
        robot_cursor_flags = 2'b00;
        robot_type         = 5'b00000;
        if (mode == 1) begin
            sprite = 4'b0001;
            case ({pixel_y[5], pixel_x[6:5]})
                3'b000: robot_cursor_flags = 2'b01;
                3'b001: robot_cursor_flags = 2'b10;
                3'b010: sprite = 4'b1111;
                3'b011: begin robot_cursor_flags = 2'b10; robot_type = 5'b00011; end
                3'b100: sprite = 4'b0110;
                3'b101: sprite = 4'b0000;
                3'b110: begin robot_cursor_flags = 2'b10; robot_type = 5'b01000; end
                default: begin robot_cursor_flags = 2'b10; robot_type = 5'b00100; end
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Stops at the negedge just before the tick that registers pixel (x,y).
    task automatic run_to(input int x, input int y);
        int n = 0;
        @(negedge clock_50);
        while (!(m_tog && m_h == x && m_v == y) && n < 2 * FRAME_CLKS) begin
            @(negedge clock_50);
            n++;
        end
        check($sformatf("reach_%0d_%0d", x, y), 32'(n < 2 * FRAME_CLKS), 32'd1);
        check($sformatf("pixel_x_%0d", x), 32'(pixel_x), 32'(x));
        check($sformatf("pixel_y_%0d", y), 32'(pixel_y), 32'(y));
    endtask

    task automatic pix(input int x, input int y, input logic [23:0] exp);
        run_to(x, y);
        @(negedge clock_50);
        check($sformatf("rgb_%0d_%0d", x, y), 32'(rgb), 32'(exp));
    endtask

    initial begin
        int hs_low, hs_pulses, vs_low, vs_pulses, blank_hi, bad_px;
        logic prev_hs, prev_vs;
        reset_key = 1'b0;
        repeat (3) @(negedge clock_50);
        check("rst_pixel_x", 32'(pixel_x), 32'd0);
        check("rst_pixel_y", 32'(pixel_y), 32'd0);
        check("rst_rgb", 32'(rgb), 32'd0);
        check("rst_hs", 32'(vga_hs), 32'd1);
        check("rst_vs", 32'(vga_vs), 32'd1);
        check("rst_blank_n", 32'(vga_blank_n), 32'd0);
        check("rst_vga_clk", 32'(vga_clk), 32'd0);

        // One full frame of trash tiles: sync pulse counts/widths and every pixel colour.
        reset_key = 1'b1;
        hs_low = 0; hs_pulses = 0; vs_low = 0; vs_pulses = 0; blank_hi = 0; bad_px = 0;
        prev_hs = 1'b1; prev_vs = 1'b1;
        for (int i = 0; i < FRAME_CLKS; i++) begin
            @(negedge clock_50);
            if (!vga_hs) begin hs_low++; if (prev_hs) hs_pulses++; end
            if (!vga_vs) begin vs_low++; if (prev_vs) vs_pulses++; end
            if (vga_blank_n) begin
                blank_hi++;
                if (rgb !== 24'h8B4513) bad_px++;
            end else if (rgb !== 24'h000000) begin
                bad_px++;
            end
            prev_hs = vga_hs;
            prev_vs = vga_vs;
        end
        check("hs_pulses", 32'(hs_pulses), 32'd72);
        check("hs_low_clks", 32'(hs_low), 32'd1152);
        check("vs_pulses", 32'(vs_pulses), 32'd1);
        check("vs_low_clks", 32'(vs_low), 32'd576);
        check("blank_hi_clks", 32'(blank_hi), 32'd16384);
        check("trash_bad_px", 32'(bad_px), 32'd0);

        // Tile map frame, pixels visited in raster order.
        mode = 1;
        pix(0, 5, CUR_RGB);
        pix(5, 5, 24'hF0F0F0);
        pix(31, 5, CUR_RGB);
        pix(48, 5, 24'hFF0000);
        pix(80, 5, 24'hFF00FF);
        pix(112, 5, 24'hFFFFFF);
        pix(100, 20, 24'hFF0000);
        pix(5, 31, CUR_RGB);
        pix(5, 40, 24'h000000);
        pix(40, 40, 24'h808080);
        pix(112, 40, 24'hFF0000);
        pix(70, 48, 24'hFF0000);
        pix(92, 48, 24'hFFFFFF);
        pix(112, 60, 24'hFFFFFF);

        // Mid-frame reset aborts at once, then the raster restarts at (0,0).
        run_to(100, 50);
        reset_key = 1'b0;
        #1;
        check("mid_pixel_x", 32'(pixel_x), 32'd0);
        check("mid_pixel_y", 32'(pixel_y), 32'd0);
        check("mid_rgb", 32'(rgb), 32'd0);
        check("mid_hs", 32'(vga_hs), 32'd1);
        check("mid_vs", 32'(vga_vs), 32'd1);
        check("mid_blank_n", 32'(vga_blank_n), 32'd0);
        check("mid_vga_clk", 32'(vga_clk), 32'd0);
        repeat (2) @(negedge clock_50);
        reset_key = 1'b1;
        @(negedge clock_50);
        check("rel1_vga_clk", 32'(vga_clk), 32'd1);
        check("rel1_blank_n", 32'(vga_blank_n), 32'd0);
        check("rel1_pixel_x", 32'(pixel_x), 32'd0);
        @(negedge clock_50);
        check("rel2_vga_clk", 32'(vga_clk), 32'd0);
        check("rel2_blank_n", 32'(vga_blank_n), 32'd1);
        check("rel2_rgb", 32'(rgb), 32'(CUR_RGB));
        check("rel2_pixel_x", 32'(pixel_x), 32'd1);
        check("rel2_pixel_y", 32'(pixel_y), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/vga_renderer.md
VGA_RENDERER -- requirements
Module: vga_renderer

Interface
REQ-001 Parameter H_VISIBLE, 640, visible pixels per line; H_FRONT 16, H_SYNC 96, H_BACK 48 complete the 800-tick line.
REQ-002 Parameter V_VISIBLE, 480, visible lines per frame; V_FRONT 10, V_SYNC 2, V_BACK 33 complete the 525-line frame.
REQ-003 clock_50  input  1  system clock, 50 MHz; the block has one clock.
REQ-004 reset_key  input  1  reset, asynchronous, active-low.
REQ-005 pixel_x  output  10  column to the world, 0..639.
REQ-006 pixel_y  output  10  row to the world, 0..479.
REQ-007 sprite  input  4  tile code returned combinationally by the world for pixel_x/pixel_y.
REQ-008 robot_cursor_flags  input  2  bit1 = robot in tile, bit0 = cursor in tile.
REQ-009 robot_type  input  5  one-hot orientation: 00010 N, 00100 S, 01000 E, 10000 W, 00000 none.
REQ-010 vga_r, vga_g, vga_b  output  8 each  pixel colour.
REQ-011 vga_hs, vga_vs  output  1 each  active-low sync.
REQ-012 vga_blank_n  output  1  high during the visible region.
REQ-013 vga_clk  output  1  25 MHz pixel clock equal to the internal tick toggle.

Function
REQ-014 A toggle register shall produce a pixel tick every second clock_50 cycle; the counters advance only on a tick.
REQ-015 h_count shall count 0..799 and wrap to 0; v_count shall increment when h_count wraps and shall wrap 524 -> 0.
REQ-016 pixel_x shall be h_count when h_count < 640, else 0; pixel_y shall be v_count when v_count < 480, else 0.
REQ-017 Output stage: one register stage, one tick of latency; RGB, hs, vs and blank_n shall all be delayed identically.
REQ-018 The output stage shall capture sprite, flags, robot_type and local offsets pixel_x[4:0]/pixel_y[4:0] on the same tick.
REQ-019 hsync shall be low for h_count 656..751; vsync shall be low for v_count 490..491; both shall be high elsewhere.
REQ-020 Outside the visible region RGB shall be 0 and vga_blank_n shall be 0.
REQ-021 Palette: 0000 wall = 80/80/80; 0001 free_path = F0/F0/F0; 0011 trash_1 = 8B/45/13; 0110 black_block = 00/00/00; any other code = FF/00/FF.
REQ-022 When flags[1]=1, the 32x32 tile shall be FF/00/00.
REQ-023 The robot tile shall carry an 8x8 FF/FF/FF marker: N local_y 0..7, x 12..19; S y 24..31, x 12..19; E x 24..31, y 12..19; W x 0..7, y 12..19.
REQ-024 When flags[1]=1 and robot_type=00000, the tile shall be red with no marker.
REQ-025 When flags[1]=1 and robot_type is not one-hot, the block shall render the north marker.
REQ-026 Colour priority: marker > robot fill > cursor outline > palette.

Reset
REQ-027 While reset_key=0: counters, toggle, pixel_x and pixel_y = 0; RGB = 0; hs and vs = 1; blank_n = 0; vga_clk = 0.
REQ-028 Reset asserted mid-frame shall abort immediately.
REQ-029 The first tick after release shall output h_count=0, v_count=0.

Configuration
REQ-030 Macro CURSOR_OVERLAY_EN defined: when flags[0]=1, the 2-pixel tile border (local x or y in 0,1,30,31) shall be FF/FF/00.
REQ-031 CURSOR_OVERLAY_EN undefined: flags[0] shall be ignored and the outline logic shall be absent.

Verification
REQ-032 Reset, then run 800x525x2 clock_50 cycles -> exactly one vs low pulse of 2 lines and 525 hs pulses, each 96 ticks.
REQ-033 World model drives sprite=0011 everywhere -> every visible pixel is 8B/45/13 one tick after the pixel_x/pixel_y presentation; blank pixels are 0.
REQ-034 flags=10, robot_type=01000 at tile (x 64..95, y 32..63) -> pixel (92,48) is FFFFFF; (70,48) is FF0000.
REQ-035 Cursor at tile (0,0), sprite=0001, CURSOR_OVERLAY_EN defined -> (0,5) and (31,5) are FFFF00, (5,5) is F0F0F0; undefined -> all F0F0F0.
REQ-036 reset_key low at h_count=300, v_count=200 -> outputs at reset values; after release, counting restarts at (0,0).
REQ-037 sprite=1111 -> FF00FF; sprite=0110 -> 000000.
